// File: rtl/math_unit.sv
// Sequential add/sub/neg (latency 2) and optional shift-add multiply (MATH_UNIT_MUL_EN, latency WIDTH+2).
// start is only sampled in IDLE; Y and the flags change together with the done pulse.
module math_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_NEG = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_res_c;
  logic             r_res_v;
  logic [WIDTH-1:0] r_y;
  logic             r_c;
  logic             r_v;
  logic             r_done;

  logic             w_accept;
  logic             w_go_mul;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_mul_y;
  logic             w_mul_hi;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic [1:0]       w_next;

  assign w_accept = (r_state == S_IDLE) && start;

`ifdef MATH_UNIT_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  // Multiplier starts in the low half; each step adds A into the high half and shifts right.
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH:0]     w_hi;

  assign w_hi       = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_last = (r_cnt == CW'(WIDTH - 1));
  assign w_go_mul   = (op == OP_MUL);
  assign w_mul_y    = r_acc[WIDTH-1:0];
  assign w_mul_hi   = |r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= {{WIDTH{1'b0}}, B};
      r_cnt <= '0;
    end else if (r_state == S_MUL) begin
      r_acc <= {w_hi, r_acc[WIDTH-1:1]};
      r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  assign w_mul_last = 1'b1;
  assign w_go_mul   = 1'b0;
  assign w_mul_y    = '0;
  assign w_mul_hi   = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_go_mul ? S_MUL : S_CALC;
      S_MUL:   if (w_mul_last) w_next = S_CALC;
      S_CALC:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_sum = {1'b0, r_a} + {1'b0, r_b};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_sum = {1'b0, r_a} + {1'b0, ~r_b} + (WIDTH+1)'(1);
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_NEG: begin
        w_res = ~r_a + WIDTH'(1);
        w_c   = (r_a == '0);
        w_v   = (r_a == {1'b1, {(WIDTH-1){1'b0}}});
      end
      default: begin
        w_res = w_mul_y;
        w_c   = w_mul_hi;
        w_v   = w_mul_hi;
      end
    endcase
  end

  // The result is staged in r_res so the visible outputs only move with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_res_c <= 1'b0;
      r_res_v <= 1'b0;
      r_y     <= '0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DONE);
      if (w_accept) begin
        r_op <= op;
        r_a  <= A;
        r_b  <= B;
      end
      if (r_state == S_CALC) begin
        r_res   <= w_res;
        r_res_c <= w_c;
        r_res_v <= w_v;
      end
      if (r_state == S_DONE) begin
        r_y <= r_res;
        r_c <= r_res_c;
        r_v <= r_res_v;
      end
    end
  end

  assign busy     = (r_state != S_IDLE) || r_done;
  assign done     = r_done;
  assign Y        = r_y;
  assign carry    = r_c;
  assign overflow = r_v;
  assign zero     = (r_y == '0);
endmodule
